// File: rtl/fetch_queue.sv
// Instruction fetch unit with a 4-entry {pc, instr} queue between program memory and decode.
// Build option FETCH_MISALIGN_CHECK_EN: a misaligned redirect halts fetch and raises misalign_o.
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0040_0000)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] pc_o,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic                  misalign_o
);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [1:0]            r_rd_ptr;
  logic [1:0]            r_wr_ptr;
  logic [2:0]            r_count;
  logic [DATA_WIDTH-1:0] r_q_pc    [4];
  logic [DATA_WIDTH-1:0] r_q_instr [4];

  logic                  w_halt;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_halt;
  logic r_misalign;
  logic w_misaligned;

  assign w_misaligned      = |redirect_pc_i[1:0];
  assign w_redirect_target = redirect_pc_i;
  assign w_halt            = r_halt;
  assign misalign_o        = r_misalign;

  // Halt and the sticky flag are released only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halt     <= 1'b0;
      r_misalign <= 1'b0;
    end else if (redirect_i && !r_halt && w_misaligned) begin
      r_halt     <= 1'b1;
      r_misalign <= 1'b1;
    end
  end
`else
  assign w_redirect_target = redirect_pc_i & ~DATA_WIDTH'(3);
  assign w_halt            = 1'b0;
  assign misalign_o        = 1'b0;
`endif

  assign pc_o       = r_pc;
  assign valid_o    = (r_count != 3'd0);
  assign instr_o    = r_q_instr[r_rd_ptr];
  assign instr_pc_o = r_q_pc[r_rd_ptr];

  assign w_full = (r_count == 3'd4);
  assign w_pop  = valid_o && ready_i;
  // A pop frees a slot in the same cycle, so a full queue can still accept a push.
  assign w_push = !redirect_i && !w_halt && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_pc;
      r_q_instr[r_wr_ptr] <= instr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else if (redirect_i && !w_halt) begin
      r_pc     <= w_redirect_target;
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
        r_pc     <= r_pc + DATA_WIDTH'(4);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_count <= r_count + 3'(w_push) - 3'(w_pop);
    end
  end

endmodule
